// File: rtl/alu_issue_ctrl_if.sv
// Decode-side issue handshake and downstream result handshake for alu_issue_ctrl.
// Optional res_illegal is present only when ALU_ISSUE_ILLEGAL_EN is defined.
`timescale 1ns/1ps
interface alu_issue_ctrl_if #(parameter int n = 32);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_aluop;
  logic [2:0]   in_funct3;
  logic         in_funct7b5;
  logic [n-1:0] in_a;
  logic [n-1:0] in_b;
  logic         res_valid;
  logic         res_ready;
  logic [n-1:0] res_data;
  logic         res_zero;
  logic         res_br_taken;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic         res_illegal;
`endif

  modport master (
    output in_valid, in_aluop, in_funct3, in_funct7b5, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_zero, res_br_taken
`ifdef ALU_ISSUE_ILLEGAL_EN
    , input res_illegal
`endif
  );

  modport slave (
    input  in_valid, in_aluop, in_funct3, in_funct7b5, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_zero, res_br_taken
`ifdef ALU_ISSUE_ILLEGAL_EN
    , output res_illegal
`endif
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue/decode stage: accept op, drive ALU one cycle, capture result, resolve BEQ/BNE.
// Latency: result valid one edge after the EXEC cycle; stalls while result unconsumed. Option: ALU_ISSUE_ILLEGAL_EN.
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_issue_ctrl_if.slave io,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [n-1:0] alu_out,
  input  logic         alu_zflag
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic       take;
  logic [3:0] dec_sel;
  logic       dec_illegal;
  logic       op_branch;
  logic [2:0] op_f3;
  logic       op_illegal;
  logic       br_taken;
  logic       res_zero_q;
  logic       res_br_q;
  logic [n-1:0] res_data_q;

  assign take = io.in_valid && io.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take) state_nxt = EXEC;
      EXEC: state_nxt = DONE;
      DONE: if (io.res_ready) state_nxt = io.in_valid ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state == IDLE) || (state == DONE && io.res_ready);
    io.res_valid = (state == DONE);
  end

  // Unlisted encodings fall through to 1111 so the ALU yields 0.
  always_comb begin
    dec_sel     = 4'b1111;
    dec_illegal = 1'b1;
    case (io.in_aluop)
      2'b00: begin dec_sel = 4'b0010; dec_illegal = 1'b0; end
      2'b01: begin
        dec_sel     = 4'b0110;
        dec_illegal = !(io.in_funct3 == 3'b000 || io.in_funct3 == 3'b001);
      end
      2'b10: begin
        case (io.in_funct3)
          3'b000:  begin dec_sel = io.in_funct7b5 ? 4'b0110 : 4'b0010; dec_illegal = 1'b0; end
          3'b111:  begin dec_sel = 4'b0000; dec_illegal = 1'b0; end
          3'b110:  begin dec_sel = 4'b0001; dec_illegal = 1'b0; end
          default: ;
        endcase
      end
      2'b11: begin
        case (io.in_funct3)
          3'b000:  begin dec_sel = 4'b0010; dec_illegal = 1'b0; end
          3'b111:  begin dec_sel = 4'b0000; dec_illegal = 1'b0; end
          3'b110:  begin dec_sel = 4'b0001; dec_illegal = 1'b0; end
          default: ;
        endcase
      end
    endcase
  end

  // Only funct3 000 (BEQ) and 001 (BNE) survive as legal branches.
  assign br_taken = op_branch && !op_illegal && (op_f3[0] ? !alu_zflag : alu_zflag);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= 4'b1111;
      op_branch  <= 1'b0;
      op_f3      <= 3'b000;
      op_illegal <= 1'b0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_br_q   <= 1'b0;
    end else begin
      if (take) begin
        alu_a      <= io.in_a;
        alu_b      <= io.in_b;
        alu_sel    <= dec_sel;
        op_branch  <= (io.in_aluop == 2'b01);
        op_f3      <= io.in_funct3;
        op_illegal <= dec_illegal;
      end
      if (state == EXEC) begin
        res_data_q <= alu_out;
        res_zero_q <= alu_zflag;
        res_br_q   <= br_taken;
      end
    end
  end

  assign io.res_data     = res_data_q;
  assign io.res_zero     = res_zero_q;
  assign io.res_br_taken = res_br_q;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic res_illegal_q;
  always_ff @(posedge clk) begin
    if (rst)                res_illegal_q <= 1'b0;
    else if (state == EXEC) res_illegal_q <= op_illegal;
  end
  assign io.res_illegal = res_illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboarded bench for alu_issue_ctrl with a behavioural ALU attached.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_zflag;

  alu_issue_ctrl_if #(.n(32)) io ();

  alu_issue_ctrl #(.n(32)) dut (
    .clk(clk), .rst(rst), .io(io),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zflag(alu_zflag)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_sel)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      default: alu_out = 32'h0;
    endcase
  end
  assign alu_zflag = (alu_out == 32'h0);

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [3:0] m_sel(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    case (op)
      2'd0: return 4'b0010;
      2'd1: return 4'b0110;
      default: begin
        if (f3 == 3'b000) return (op == 2'd2 && f7) ? 4'b0110 : 4'b0010;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        return 4'b1111;
      end
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [3:0] s;
    s = m_sel(op, f3, f7);
    case (s)
      4'b0000: e.data = a & b;
      4'b0001: e.data = a | b;
      4'b0010: e.data = a + b;
      4'b0110: e.data = a - b;
      default: e.data = 32'h0;
    endcase
    e.zero = (e.data == 32'h0);
    e.ill  = (op == 2'd1) ? (f3 > 3'd1) : (s == 4'b1111);
    e.br   = (op == 2'd1) && !e.ill && ((f3 == 3'b000) ? e.zero : !e.zero);
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input bit push);
    bit ok = 0;
    io.in_valid = 1'b1; io.in_aluop = op; io.in_funct3 = f3;
    io.in_funct7b5 = f7; io.in_a = a; io.in_b = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (io.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout in_ready=%b want 1", io.in_ready);
      io.in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back(model(op, f3, f7, a, b));
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    io.in_aluop = 2'($urandom); io.in_funct3 = 3'($urandom);
    io.in_funct7b5 = 1'($urandom); io.in_a = $urandom; io.in_b = $urandom;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) begin ok = 1; break; end
      @(posedge clk);
    end
    @(posedge clk); #1;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; io.in_valid = 1'b0; io.res_ready = 1'b0;
    io.in_aluop = 2'd0; io.in_funct3 = 3'd0; io.in_funct7b5 = 1'b0;
    io.in_a = 32'hDEAD; io.in_b = 32'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({io.res_valid, io.in_ready, alu_sel} !== {1'b0, 1'b1, 4'b1111}) begin
      miscompares++;
      $display("FAIL reset_ctrl got valid=%b ready=%b sel=%b want 0 1 1111",
               io.res_valid, io.in_ready, alu_sel);
    end
    vectors++;
    if ({alu_a, alu_b, io.res_data, io.res_zero, io.res_br_taken} !== 98'h0) begin
      miscompares++;
      $display("FAIL reset_data got a=%h b=%h d=%h z=%b br=%b want all 0",
               alu_a, alu_b, io.res_data, io.res_zero, io.res_br_taken);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    io.res_ready = 1'b1;
    issue(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 1);
    vectors++;
    if ({alu_sel, alu_a, alu_b, io.res_valid} !== {4'b0010, 32'd5, 32'd7, 1'b0}) begin
      miscompares++;
      $display("FAIL add_issue got sel=%b a=%0d b=%0d valid=%b want 0010 5 7 0",
               alu_sel, alu_a, alu_b, io.res_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({io.res_valid, io.res_data} !== {1'b1, 32'd12}) begin
      miscompares++;
      $display("FAIL add_latency got valid=%b data=%0d want 1 12", io.res_valid, io.res_data);
    end
    drain();
  endtask

  task automatic test_sub_zero();
    issue(2'b10, 3'b000, 1'b1, 32'h1234, 32'h1234, 1);
    vectors++;
    if (alu_sel !== 4'b0110) begin
      miscompares++;
      $display("FAIL sub_sel got %b want 0110", alu_sel);
    end
    drain();
  endtask

  task automatic test_branch();
    issue(2'b01, 3'b000, 1'b0, 32'd9, 32'd9, 1);
    issue(2'b01, 3'b001, 1'b0, 32'd9, 32'd9, 1);
    issue(2'b01, 3'b001, 1'b0, 32'd9, 32'd3, 1);
    issue(2'b01, 3'b000, 1'b0, 32'd9, 32'd3, 1);
    drain();
  endtask

  task automatic test_backpressure();
    io.res_ready = 1'b0;
    issue(2'b11, 3'b111, 1'b0, 32'hF0F0, 32'h0FF0, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({io.res_valid, io.res_data, io.in_ready} !== {1'b1, 32'h00F0, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold cyc=%0d got valid=%b data=%h ready=%b want 1 000000f0 0",
                 i, io.res_valid, io.res_data, io.in_ready);
      end
      @(posedge clk); #1;
    end
    io.res_ready = 1'b1;
    issue(2'b11, 3'b110, 1'b0, 32'hF0F0, 32'h0FF0, 1);
    vectors++;
    if ({io.res_valid, alu_sel} !== {1'b0, 4'b0001}) begin
      miscompares++;
      $display("FAIL same_edge got valid=%b sel=%b want 0 0001", io.res_valid, alu_sel);
    end
    drain();
  endtask

  task automatic test_illegal();
    issue(2'b10, 3'b100, 1'b0, 32'h55, 32'h22, 1);
    vectors++;
    if (alu_sel !== 4'b1111) begin
      miscompares++;
      $display("FAIL illegal_sel got %b want 1111", alu_sel);
    end
    issue(2'b11, 3'b010, 1'b1, 32'h7, 32'h9, 1);
    drain();
  endtask

  task automatic test_rst_exec();
    io.res_ready = 1'b1;
    issue(2'b10, 3'b000, 1'b0, 32'd3, 32'd4, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({io.res_valid, alu_sel, io.in_ready} !== {1'b0, 4'b1111, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_exec got valid=%b sel=%b ready=%b want 0 1111 1",
               io.res_valid, alu_sel, io.in_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (io.res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_abort cyc=%0d got valid=%b want 0", i, io.res_valid);
      end
    end
    issue(2'b00, 3'b101, 1'b1, 32'd100, 32'd23, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops[8] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [2:0] f3s[8] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b011, 3'b001, 3'b110, 3'b000};
    logic       f7s[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    time t0;
    io.res_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 8; i++)
      issue(ops[i], f3s[i], f7s[i], $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, 1);
    vectors++;
    if (($time - t0) != 150) begin
      miscompares++;
      $display("FAIL throughput got %0t want 150 for 8 ops", $time - t0);
    end
    drain();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && io.res_valid && io.res_ready) begin
          exp_t e;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result got data=%h want no result", io.res_data);
          end else begin
            e = sb.pop_front();
            if ({io.res_data, io.res_zero, io.res_br_taken} !== {e.data, e.zero, e.br}) begin
              miscompares++;
              $display("FAIL result got data=%h z=%b br=%b want %h %b %b",
                       io.res_data, io.res_zero, io.res_br_taken, e.data, e.zero, e.br);
            end
`ifdef ALU_ISSUE_ILLEGAL_EN
            vectors++;
            if (io.res_illegal !== e.ill) begin
              miscompares++;
              $display("FAIL res_illegal got %b want %b", io.res_illegal, e.ill);
            end
`endif
          end
        end
      end
    join_none

    test_reset();
    test_add();
    test_sub_zero();
    test_branch();
    test_backpressure();
    test_illegal();
    test_rst_exec();
    test_back_to_back();

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got time=%0t want finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
